// File: rtl/decodificador_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : decodificador_pkg                                             |
// | Purpose  : Shared helpers for the scanning decoder: output-width and     |
// |            prescaler-width derivation, and the one-hot line pattern.     |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package decodificador_pkg;

  // Output width: one line per select code.
  function automatic int ancho_salida(input int n);
    return 1 << n;
  endfunction

  // Prescaler width: enough bits to hold 0..div-1, never less than one bit.
  function automatic int ancho_prescaler(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  // Mask covering the 2^n live lines inside a 64-bit container.
  function automatic logic [63:0] mascara_lineas(input int n);
    return {64{1'b1}} >> (64 - (1 << n));
  endfunction

  // Active-high one-hot pattern for line idx of a 2^n-line decoder.
  function automatic logic [63:0] onehot(input int n, input int unsigned idx);
    return (64'd1 << idx) & mascara_lineas(n);
  endfunction

endpackage : decodificador_pkg
`default_nettype wire

// File: rtl/decodificador_barrido_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : decodificador_barrido_if                                      |
// | Purpose  : Select/control inputs and decoded outputs of the scanning     |
// |            decoder, bundled as one bus.                                  |
// | Ports    : master drives entrada/habilitar/modo and observes             |
// |            salida/indice/cambio; slave (the decoder) is the reverse.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface decodificador_barrido_if #(
  parameter int N = 2
);
  logic [N-1:0]        entrada;
  logic                habilitar;
  logic                modo;
  logic [(1<<N)-1:0]   salida;
  logic [N-1:0]        indice;
  logic                cambio;

  modport master (
    output entrada, habilitar, modo,
    input  salida, indice, cambio
  );

  modport slave (
    input  entrada, habilitar, modo,
    output salida, indice, cambio
  );
endinterface : decodificador_barrido_if
`default_nettype wire

// File: rtl/decodificador_barrido_divisor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : divisor_barrido                                               |
// | Purpose  : Scan-rate prescaler. Counts 0..SCAN_DIV-1 while enabled and   |
// |            flags the last count so the caller can step its index.        |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            i_limpiar   - synchronous clear (wins over enable)            |
// |            i_habilitar - count enable; count is held when low            |
// |            o_tc        - high while the count sits at SCAN_DIV-1         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module divisor_barrido
  import decodificador_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_limpiar,
  input  logic i_habilitar,
  output logic o_tc
);

  localparam int                     c_ANCHO_PRE = ancho_prescaler(SCAN_DIV);
  localparam logic [c_ANCHO_PRE-1:0] c_ULTIMO    = c_ANCHO_PRE'(SCAN_DIV - 1);

  logic [c_ANCHO_PRE-1:0] r_cuenta;

  // With SCAN_DIV=1 the count never leaves 0, so tc is permanently high.
  assign o_tc = (r_cuenta == c_ULTIMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cuenta <= '0;
    end else if (i_limpiar) begin
      r_cuenta <= '0;
    end else if (i_habilitar) begin
      r_cuenta <= o_tc ? '0 : r_cuenta + c_ANCHO_PRE'(1);
    end
  end

endmodule : divisor_barrido
`default_nettype wire

// File: rtl/decodificador_barrido.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : decodificador_barrido                                         |
// | Purpose  : N-to-2^N decoder with registered outputs, enable, output      |
// |            polarity select and a self-timed scan mode that walks the     |
// |            active line through every position, seeded from entrada.    |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            bus.entrada   (in)  select value / scan seed                  |
// |            bus.habilitar (in)  1 = drive a line, 0 = all inactive+freeze |
// |            bus.modo      (in)  0 = direct decode, 1 = scan               |
// |            bus.salida    (out) decoded lines (one-cold if ACTIVE_LOW)    |
// |            bus.indice    (out) index currently driven                    |
// |            bus.cambio    (out) one-cycle pulse when salida changed       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module decodificador_barrido
  import decodificador_pkg::*;
#(
  parameter int N          = 2,
  parameter int SCAN_DIV   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  decodificador_barrido_if.slave  bus
);

  localparam int                        c_ANCHO_SALIDA = ancho_salida(N);
  // Pattern of an idle bus; XOR with it also applies the polarity.
  localparam logic [c_ANCHO_SALIDA-1:0] c_INACTIVO     = {c_ANCHO_SALIDA{ACTIVE_LOW}};

  logic [N-1:0]                r_indice;
  logic [N-1:0]                w_indice_sig;
  logic                        r_modo_q;
  logic [c_ANCHO_SALIDA-1:0]   r_salida;
  logic [c_ANCHO_SALIDA-1:0]   w_salida_sig;
  logic                        r_cambio;
  logic                        w_sembrar;
  logic                        w_correr;
  logic                        w_tc;

  // Seeding happens on every enabled direct edge and on the first enabled
  // edge after modo rises. modo_q follows modo even while disabled, so a
  // rise that happens during a disabled stretch is absorbed and the scan
  // resumes where it stopped instead of re-seeding.
  assign w_sembrar = bus.habilitar & ~(bus.modo & r_modo_q);
  assign w_correr  = bus.habilitar &  bus.modo & r_modo_q;

  divisor_barrido #(
    .SCAN_DIV (SCAN_DIV)
  ) u_divisor (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_limpiar   (w_sembrar),
    .i_habilitar (w_correr),
    .o_tc        (w_tc)
  );

  always_comb begin
    w_indice_sig = r_indice;
    if (w_sembrar) begin
      w_indice_sig = bus.entrada;
    end else if (w_correr && w_tc) begin
      // N-bit add wraps 2^N-1 back to 0.
      w_indice_sig = r_indice + N'(1);
    end
  end

  // Polarity is folded in here so the output register holds the final levels.
  assign w_salida_sig = bus.habilitar
                      ? (c_ANCHO_SALIDA'(onehot(N, 32'(w_indice_sig))) ^ c_INACTIVO)
                      : c_INACTIVO;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_indice <= '0;
      r_modo_q <= 1'b0;
      r_salida <= c_INACTIVO;
      r_cambio <= 1'b0;
    end else begin
      r_indice <= w_indice_sig;
      r_modo_q <= bus.modo;
      r_salida <= w_salida_sig;
      r_cambio <= (w_salida_sig != r_salida);
    end
  end

  assign bus.salida = r_salida;
  assign bus.indice = r_indice;
  assign bus.cambio = r_cambio;

endmodule : decodificador_barrido
`default_nettype wire

// File: tb/tb_decodificador_barrido.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_decodificador_barrido                                      |
// | Purpose  : Scoreboard bench for decodificador_barrido. Three instances:  |
// |            A: N=2 SCAN_DIV=3 active-high                                 |
// |            B: N=3 SCAN_DIV=1 active-low                                  |
// |            C: N=2 SCAN_DIV=4 active-high                                 |
// |            Stimulus is applied on the falling edge; a reference model    |
// |            pushes the expected outputs, a monitor pops and compares them |
// |            after every rising edge.                                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_decodificador_barrido;

  typedef struct {
    logic [63:0] sal;
    int          idx;
    bit          camb;
  } esperado_t;

  logic clk;
  logic rst_n;

  decodificador_barrido_if #(.N(2)) ifa ();
  decodificador_barrido_if #(.N(3)) ifb ();
  decodificador_barrido_if #(.N(2)) ifc ();

  decodificador_barrido #(.N(2), .SCAN_DIV(3), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  decodificador_barrido #(.N(3), .SCAN_DIV(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));
  decodificador_barrido #(.N(2), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc));

  // Instance parameters as seen by the model.
  int p_n   [3] = '{2, 3, 2};
  int p_div [3] = '{3, 1, 4};
  bit p_al  [3] = '{1'b0, 1'b1, 1'b0};

  // Stimulus per instance.
  logic [5:0] ent [3];
  bit         hab [3];
  bit         mod [3];

  // Model state: current index, enabled scan cycles already spent on it,
  // previous modo, previous salida.
  int          m_idx  [3];
  int          m_held [3];
  bit          m_mq   [3];
  logic [63:0] m_sal  [3];

  esperado_t sb [$];
  int checks   = 0;
  int failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural rules: a line is lit only when enabled; direct mode and the
  // first scan cycle take the index from entrada; otherwise each index is
  // held for SCAN_DIV enabled scan cycles, then the next one (mod 2^N).
  task automatic model_step(input int i, input bit en_reset);
    logic [63:0] nuevo;
    logic [63:0] mascara;
    int          lineas;
    esperado_t   e;
    lineas  = 1 << p_n[i];
    mascara = (64'd1 << lineas) - 64'd1;
    if (en_reset) begin
      m_idx[i]  = 0;
      m_held[i] = 0;
      m_mq[i]   = 1'b0;
      nuevo     = 64'd0;
    end else begin
      if (hab[i]) begin
        if (!mod[i] || !m_mq[i]) begin
          m_idx[i]  = int'(ent[i]) % lineas;
          m_held[i] = 0;
        end else begin
          m_held[i]++;
          if (m_held[i] == p_div[i]) begin
            m_held[i] = 0;
            m_idx[i]  = (m_idx[i] + 1) % lineas;
          end
        end
        nuevo = 64'd1 << m_idx[i];
      end else begin
        nuevo = 64'd0;
      end
      m_mq[i] = mod[i];
    end
    if (p_al[i]) nuevo = ~nuevo & mascara;
    e.sal  = nuevo;
    e.idx  = m_idx[i];
    e.camb = en_reset ? 1'b0 : (nuevo != m_sal[i]);
    m_sal[i] = nuevo;
    sb.push_back(e);
  endtask

  // Apply the staged inputs on the falling edge and queue what the next
  // rising edge must produce.
  task automatic tick(input bit en_reset);
    @(negedge clk);
    rst_n         = ~en_reset;
    ifa.entrada   = ent[0][1:0];
    ifa.habilitar = hab[0];
    ifa.modo      = mod[0];
    ifb.entrada   = ent[1][2:0];
    ifb.habilitar = hab[1];
    ifb.modo      = mod[1];
    ifc.entrada   = ent[2][1:0];
    ifc.habilitar = hab[2];
    ifc.modo      = mod[2];
    for (int i = 0; i < 3; i++) model_step(i, en_reset);
  endtask

  task automatic look();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rising edge with a pending expectation is compared.
  initial begin
    esperado_t   e;
    logic [63:0] a_sal;
    int          a_idx;
    logic        a_camb;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() >= 3) begin
        for (int i = 0; i < 3; i++) begin
          e = sb.pop_front();
          case (i)
            0:       begin a_sal = 64'(ifa.salida); a_idx = int'(ifa.indice); a_camb = ifa.cambio; end
            1:       begin a_sal = 64'(ifb.salida); a_idx = int'(ifb.indice); a_camb = ifb.cambio; end
            default: begin a_sal = 64'(ifc.salida); a_idx = int'(ifc.indice); a_camb = ifc.cambio; end
          endcase
          chk($sformatf("sb%0d_salida", i), a_sal, e.sal);
          chk($sformatf("sb%0d_indice", i), 64'(a_idx), 64'(e.idx));
          chk($sformatf("sb%0d_cambio", i), 64'(a_camb), 64'(e.camb));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ent[i] = 6'd0;
      hab[i] = 1'b1;
      mod[i] = 1'b0;
      m_sal[i] = 64'd0;
    end
    ent[0] = 6'd3;
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    look();

    // Direct decode, one new code per cycle.
    for (int v = 0; v < 4; v++) begin
      ent[0] = 6'(v);
      tick(1'b0);
      look();
      chk("direct_salida", 64'(ifa.salida), 64'd1 << v);
      chk("direct_cambio", 64'(ifa.cambio), 64'd1);
    end

    // Active-low polarity, N=3.
    ent[1] = 6'd5;
    tick(1'b0);
    look();
    chk("pol_direct", 64'(ifb.salida), 64'hDF);
    hab[1] = 1'b0;
    tick(1'b0);
    look();
    chk("pol_disabled", 64'(ifb.salida), 64'hFF);
    hab[1] = 1'b1;

    // Scan seeded at 2 with SCAN_DIV=3: 2,2,2,3,3,3,0,0,0,1,1,1,2.
    ent[0] = 6'd2;
    mod[0] = 1'b1;
    tick(1'b0);
    look();
    chk("scan_seed", 64'(ifa.indice), 64'd2);
    for (int k = 1; k <= 12; k++) begin
      ent[0] = 6'($urandom);
      tick(1'b0);
      look();
      chk("scan_indice", 64'(ifa.indice), 64'((2 + k / 3) % 4));
      chk("scan_cambio", 64'(ifa.cambio), 64'(k % 3 == 0));
    end

    // Asynchronous reset in the middle of the scan.
    tick(1'b1);
    #1;
    chk("rst_salida_a", 64'(ifa.salida), 64'd0);
    chk("rst_indice_a", 64'(ifa.indice), 64'd0);
    chk("rst_cambio_a", 64'(ifa.cambio), 64'd0);
    chk("rst_salida_b", 64'(ifb.salida), 64'hFF);
    mod[0] = 1'b0;
    tick(1'b0);

    // Freeze: SCAN_DIV=4, seed 1, two cycles on 1, five disabled cycles.
    ent[2] = 6'd1;
    tick(1'b0);
    mod[2] = 1'b1;
    tick(1'b0);
    tick(1'b0);
    look();
    chk("freeze_pre", 64'(ifc.indice), 64'd1);
    hab[2] = 1'b0;
    tick(1'b0);
    look();
    chk("freeze_salida", 64'(ifc.salida), 64'd0);
    chk("freeze_cambio", 64'(ifc.cambio), 64'd1);
    repeat (4) tick(1'b0);
    hab[2] = 1'b1;
    tick(1'b0);
    look();
    chk("resume_1a", 64'(ifc.indice), 64'd1);
    tick(1'b0);
    look();
    chk("resume_1b", 64'(ifc.indice), 64'd1);
    tick(1'b0);
    look();
    chk("resume_2", 64'(ifc.indice), 64'd2);
    chk("resume_cambio", 64'(ifc.cambio), 64'd1);

    // SCAN_DIV=1 scan, exit to direct, then re-enter.
    ent[1] = 6'd6;
    mod[1] = 1'b1;
    tick(1'b0);
    look();
    chk("div1_seed", 64'(ifb.indice), 64'd6);
    tick(1'b0);
    look();
    chk("div1_step", 64'(ifb.indice), 64'd7);
    tick(1'b0);
    look();
    chk("div1_wrap", 64'(ifb.indice), 64'd0);
    mod[1] = 1'b0;
    ent[1] = 6'd0;
    tick(1'b0);
    look();
    chk("exit_salida", 64'(ifb.salida), 64'hFE);
    mod[1] = 1'b1;
    ent[1] = 6'd4;
    tick(1'b0);
    look();
    chk("reenter_seed", 64'(ifb.indice), 64'd4);
    tick(1'b0);
    look();
    chk("reenter_step", 64'(ifb.indice), 64'd5);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 15) == 0) mod[i] = ~mod[i];
        hab[i] = ($urandom_range(0, 7) != 0);
        ent[i] = 6'($urandom);
      end
      tick($urandom_range(0, 599) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_decodificador_barrido
`default_nettype wire

// File: doc/decodificador_barrido.md
# decodificador_barrido

Parametrised N-to-2^N one-hot decoder with registered outputs, enable, selectable output polarity, and an autonomous scan mode that steps the active line through all 2^N positions at a programmable rate. It is the next generation of the team's fixed 2-to-4 combinational decoder. It serves as a line/digit selector for multiplexed displays and chip-select fan-out. In direct mode it behaves as a clocked decoder; in scan mode it is a self-timed one-hot sequencer seeded from the select input.

## Interface
- `N`, 2, select width; output width is 2^N (legal range 1..6)
- `SCAN_DIV`, 4, clock cycles each position is held in scan mode (≥1)
- `ACTIVE_LOW`, 0, 1 = inactive lines high, active line low
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `entrada`  in  N  select value (direct) / scan seed (on scan entry)
- `habilitar`  in  1  1 = drive active line; 0 = all lines inactive, state frozen
- `modo`  in  1  0 = direct, 1 = scan
- `salida`  out  2^N  one-hot (or one-cold if ACTIVE_LOW) decoded lines, registered
- `indice`  out  N  index currently driven on `salida`, registered
- `cambio`  out  1  one-cycle pulse when `salida` differs from its previous value

## Operation
- Reset (rst_n=0, asynchronous): `salida` = all inactive (0s, or 1s if ACTIVE_LOW); `indice` = 0; `cambio` = 0; prescaler = 0; internal `modo_q` = 0.
- Active-line encoding: bit k of `salida` is active iff k == `indice` and the line is enabled; exactly one active bit when enabled, none when disabled.
- Direct mode (`modo`=0, `habilitar`=1): each edge `indice` <= `entrada`; `salida` <= onehot(`entrada`). Prescaler held at 0.
- Scan entry (`modo`=1 and `modo_q`=0, `habilitar`=1): `indice` <= `entrada`, prescaler <= 0, `salida` <= onehot(`entrada`).
- Scan run (`modo`=1, `modo_q`=1, `habilitar`=1): prescaler counts 0..SCAN_DIV-1. On the edge where prescaler == SCAN_DIV-1, prescaler <= 0 and `indice` <= `indice`+1 mod 2^N (2^N-1 wraps to 0); otherwise prescaler increments. `entrada` ignored.
- Disabled (`habilitar`=0, either mode): `salida` <= all inactive; `indice`, prescaler frozen; `modo_q` still tracks `modo`. Re-enable in scan mode resumes the same index with the preserved prescaler count. A mode rise that occurs while disabled does not seed; no re-seed occurs on re-enable.
- Scan exit (`modo` 1->0): next edge is a direct-mode edge; the prescaler clears.
- `cambio` <= (next `salida` != current `salida`); covers enable/disable transitions and scan steps.
- SCAN_DIV=1: advance every cycle while enabled.

## Timing
- Direct-mode latency: 1 cycle from `entrada`/`habilitar` to `salida`/`indice`.
- Scan: each index held exactly SCAN_DIV enabled cycles, except that disabled cycles stretch the hold time. Full period is 2^N·SCAN_DIV cycles.
- `cambio` is asserted in the same cycle as the new `salida` value (registered together).
- Reset release: first active edge evaluates normally. A `modo`=1 at release is treated as scan entry, because `modo_q` resets to 0.
- All outputs registered; there is no combinational path from input to output.

## Structure
- Shared package `decodificador_pkg`: function `onehot(N, idx)`; constant derivation `ANCHO_SALIDA = 1<<N`; prescaler width `$clog2(SCAN_DIV)` (min 1).
- One sub-module `divisor_barrido`: prescaler with clear, enable, and terminal-count output `tc`.
- Top holds `indice`, `modo_q`, `salida`, and the `cambio` logic. The polarity inversion is applied at the output register input.

## Test plan
- Reset: assert rst_n=0 mid-scan with N=2, ACTIVE_LOW=0 -> `salida`=4'b0000, `indice`=0, `cambio`=0 immediately (no clock).
- Direct: N=2, habilitar=1, entrada 0,1,2,3 on successive cycles -> `salida` 0001,0010,0100,1000 one cycle later; `cambio`=1 each cycle.
- Scan wrap: N=2, SCAN_DIV=3, entrada=2, modo 0->1 -> `indice` 2 for 3 cycles, then 3 for 3 cycles, then 0, then 1. Single-cycle `cambio` at each step. Period is 12.
- Freeze: scan with SCAN_DIV=4; drop habilitar after 2 cycles at index 1 for 5 cycles -> `salida`=0000 (cambio pulse on the drop). Re-enable -> index 1 for 2 more cycles, then 2.
- Polarity: N=3, ACTIVE_LOW=1, entrada=5, direct -> `salida`=8'b1101_1111. Disabled -> 8'hFF. After reset -> 8'hFF.
- Mode exit/SCAN_DIV=1: N=2, scan advancing every cycle; set modo=0 with entrada=0 -> next `salida`=0001. Re-enter scan -> sequence resumes from `entrada`.
